dcache_controller: RTL and testbench

DCACHE_CONTROLLER -- requirements
Module: dcache_controller

---
 rtl/dcache_controller_if.sv | 38 +++
 rtl/dcache_controller.sv | 185 ++++++++++++++++++
 tb/tb_dcache_controller.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_controller_if.sv
// Bus bundle for the direct-mapped write-through data cache: core-side request
// signals and the single-beat main-memory port.
interface dcache_controller_if;
  // Core side: a request (cpu_read or cpu_write) is consumed on the first rising
  // edge where stall=0; while stall=1 the core holds address, data and size.
  // Memory side: a beat is valid while mem_req=1 and completes on the rising edge
  // where mem_ready=1; mem_addr/mem_we/mem_be/mem_wdata are held stable until
  // then, and mem_ready seen while mem_req=0 means nothing.
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_read;
  logic        cpu_write;
  logic [1:0]  cpu_store;
  logic [31:0] cpu_rdata;
  logic        stall;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_read, cpu_write, cpu_store,
    input  mem_rdata, mem_ready,
    output cpu_rdata, stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_read, cpu_write, cpu_store,
    output mem_rdata, mem_ready,
    input  cpu_rdata, stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped data cache, 4 words per line: write-through, no-write-allocate,
// read-allocate with an in-order 4-beat refill.
module dcache_controller #(
  parameter int LINES = 16
) (
  input  logic                clk,
  input  logic                rstn,
  dcache_controller_if.slave  bus,
  output logic [1:0]          dbg_state
);

  localparam int IDX  = $clog2(LINES);
  localparam int TAGW = 28 - IDX;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;
  logic [1:0]        beat_q;

  logic              valid_q [LINES];
  logic [TAGW-1:0]   tag_q   [LINES];
  logic [31:0]       data_q  [LINES][4];

  logic [IDX-1:0]    req_idx, lat_idx;
  logic [TAGW-1:0]   req_tag, lat_tag;
  logic              req_hit, lat_hit;
  logic [31:0]       req_word;

  logic [3:0]        wr_be;
  logic [31:0]       wr_data;

  logic              start_write, start_refill, refill_we, write_hit_we;

  // In IDLE the lookup uses the live core address; in REFILL/WRITE only the
  // latched address matters, so later core changes cannot disturb a transfer.
  assign req_idx  = bus.cpu_addr[3+IDX:4];
  assign req_tag  = bus.cpu_addr[31:4+IDX];
  assign lat_idx  = addr_q[3+IDX:4];
  assign lat_tag  = addr_q[31:4+IDX];
  assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign lat_hit  = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);
  assign req_word = data_q[req_idx][bus.cpu_addr[3:2]];

  assign dbg_state = state_q;

  always_comb begin
    wr_be   = 4'b0000;
    wr_data = 32'h0;
    case (size_q)
      2'b10: begin
        wr_be   = 4'b0001 << addr_q[1:0];
        wr_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d       = state_q;
    bus.stall     = 1'b0;
    bus.cpu_rdata = 32'h0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_be    = 4'b0000;
    start_write   = 1'b0;
    start_refill  = 1'b0;
    refill_we     = 1'b0;
    write_hit_we  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cpu_write) begin
          start_write = 1'b1;
          bus.stall   = 1'b1;
          state_d     = WRITE;
        end else if (bus.cpu_read) begin
          if (req_hit) begin
            bus.cpu_rdata = req_word >> {bus.cpu_addr[1:0], 3'b000};
          end else begin
            start_refill = 1'b1;
            bus.stall    = 1'b1;
            state_d      = REFILL;
          end
        end
      end
      REFILL: begin
        bus.stall    = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_addr = {addr_q[31:4], beat_q, 2'b00};
        if (bus.mem_ready) begin
          refill_we = 1'b1;
          if (beat_q == 2'd3) state_d = IDLE;
        end
      end
      WRITE: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {addr_q[31:2], 2'b00};
        bus.mem_be    = wr_be;
        bus.mem_wdata = wr_data;
        if (bus.mem_ready) begin
          state_d      = IDLE;
          write_hit_we = lat_hit;
        end else begin
          bus.stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs and strobes are quiet for as long as reset is held.
    if (!rstn) begin
      state_d       = IDLE;
      bus.stall     = 1'b0;
      bus.cpu_rdata = 32'h0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = 32'h0;
      bus.mem_wdata = 32'h0;
      bus.mem_be    = 4'b0000;
      start_write   = 1'b0;
      start_refill  = 1'b0;
      refill_we     = 1'b0;
      write_hit_we  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 2'b00;
      beat_q  <= 2'd0;
      for (int i = 0; i < LINES; i++) valid_q[i] <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_write) begin
        addr_q  <= bus.cpu_addr;
        wdata_q <= bus.cpu_wdata;
        size_q  <= bus.cpu_store;
      end
      // The victim line is invalidated up front so an abandoned refill never
      // leaves a half-written line looking valid.
      if (start_refill) begin
        addr_q           <= bus.cpu_addr;
        beat_q           <= 2'd0;
        valid_q[req_idx] <= 1'b0;
      end
      if (refill_we) begin
        beat_q <= beat_q + 2'd1;
        if (beat_q == 2'd3) valid_q[lat_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (refill_we) begin
      data_q[lat_idx][beat_q] <= bus.mem_rdata;
      if (beat_q == 2'd3) tag_q[lat_idx] <= lat_tag;
    end
    if (write_hit_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) data_q[lat_idx][addr_q[3:2]][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed scenarios plus random loads/stores checked
// against a memory image and a per-index record of which line is resident.
module tb_dcache_controller;
  localparam int LINES = 16;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] dbg_state;

  dcache_controller_if bus ();

  dcache_controller #(.LINES(LINES)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  // ---------------- reference model ----------------
  int checks = 0;
  int errors = 0;

  logic [31:0] mem_model [int unsigned];
  logic [31:0] line_at [LINES];
  bit          line_v  [LINES];

  logic [31:0] exp_q [$];
  logic [31:0] log_addr_q [$];
  logic        log_we_q [$];
  logic [3:0]  log_be_q [$];
  logic [31:0] log_wdata_q [$];

  int mem_delay = 0;
  bit spurious  = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 4) % LINES);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin : responder
    int          wait_cnt;
    logic [31:0] held_addr;
    logic [31:0] w;
    wait_cnt = -1;
    held_addr = 32'h0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h0;
      if (bus.mem_req !== 1'b1) begin
        wait_cnt = -1;
        if (spurious) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = 32'hDEAD_BEEF;
        end
      end else begin
        if (wait_cnt < 0) begin
          wait_cnt  = (mem_delay < 0) ? int'($urandom_range(0, 2)) : mem_delay;
          held_addr = bus.mem_addr;
        end else begin
          chk("mem_addr_stable", bus.mem_addr, held_addr);
        end
        if (wait_cnt == 0) begin
          bus.mem_ready = 1'b1;
          log_addr_q.push_back(bus.mem_addr);
          log_we_q.push_back(bus.mem_we);
          log_be_q.push_back(bus.mem_be);
          log_wdata_q.push_back(bus.mem_wdata);
          if (bus.mem_we) begin
            w = mem_rd(bus.mem_addr);
            for (int b = 0; b < 4; b++)
              if (bus.mem_be[b]) w[b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
            mem_model[bus.mem_addr] = w;
          end else begin
            bus.mem_rdata = mem_rd(bus.mem_addr);
          end
          wait_cnt = -1;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_log();
    log_addr_q.delete();
    log_we_q.delete();
    log_be_q.delete();
    log_wdata_q.delete();
    exp_q.delete();
  endtask

  // Called at a falling edge; returns at the falling edge after completion.
  task automatic do_read(input logic [31:0] a, input string tag);
    logic [31:0] base;
    int          ix, n;
    bit          hit;
    base = a & 32'hFFFF_FFF0;
    ix   = idx_of(a);
    hit  = line_v[ix] && (line_at[ix] == base);
    clear_log();
    if (!hit) for (int i = 0; i < 4; i++) exp_q.push_back(base + 32'(4 * i));
    bus.cpu_addr  = a;
    bus.cpu_read  = 1'b1;
    bus.cpu_write = 1'b0;
    #1;
    chk({tag, ".stall_first"}, 32'(bus.stall), 32'(!hit));
    n = 0;
    while (bus.stall === 1'b1 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk({tag, ".timeout"}, 32'(1), 32'(0));
    chk({tag, ".rdata"}, bus.cpu_rdata, mem_rd(a & 32'hFFFF_FFFC) >> (8 * a[1:0]));
    chk({tag, ".mem_req_on_hit"}, 32'(bus.mem_req), 32'(0));
    chk({tag, ".beats"}, 32'(log_addr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < log_addr_q.size() && i < exp_q.size(); i++) begin
      chk({tag, ".beat_addr"}, log_addr_q[i], exp_q[i]);
      chk({tag, ".beat_we"}, 32'(log_we_q[i]), 32'(0));
    end
    if (!hit) chk({tag, ".min_latency"}, 32'(n >= 5), 32'(1));
    line_v[ix]  = 1'b1;
    line_at[ix] = base;
    @(negedge clk);
    bus.cpu_read = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] size, input string tag);
    logic [3:0]  be;
    logic [31:0] wd;
    int          n;
    case (size)
      2'b10:   begin be = 4'b0001 << a[1:0];              wd = {4{d[7:0]}};  end
      2'b01:   begin be = a[1] ? 4'b1100 : 4'b0011;       wd = {2{d[15:0]}}; end
      default: begin be = 4'b1111;                        wd = d;            end
    endcase
    clear_log();
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_store = size;
    bus.cpu_write = 1'b1;
    bus.cpu_read  = 1'($urandom_range(0, 1));
    #1;
    chk({tag, ".stall_first"}, 32'(bus.stall), 32'(1));
    n = 0;
    do begin
      @(negedge clk);
      bus.cpu_addr  = $urandom;
      bus.cpu_wdata = $urandom;
      bus.cpu_store = 2'($urandom_range(0, 3));
      #1;
      n++;
    end while (bus.stall === 1'b1 && n < 200);
    if (n >= 200) chk({tag, ".timeout"}, 32'(1), 32'(0));
    chk({tag, ".mem_req"}, 32'(bus.mem_req), 32'(1));
    chk({tag, ".mem_we"}, 32'(bus.mem_we), 32'(1));
    chk({tag, ".mem_addr"}, bus.mem_addr, a & 32'hFFFF_FFFC);
    chk({tag, ".mem_be"}, 32'(bus.mem_be), 32'(be));
    chk({tag, ".mem_wdata"}, bus.mem_wdata, wd);
    chk({tag, ".beats"}, 32'(log_addr_q.size()), 32'(1));
    @(negedge clk);
    bus.cpu_write = 1'b0;
    bus.cpu_read  = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : stimulus
    int n;
    bus.cpu_addr  = 32'h0000_0104;
    bus.cpu_wdata = 32'h0;
    bus.cpu_read  = 1'b1;
    bus.cpu_write = 1'b0;
    bus.cpu_store = 2'b00;
    for (int i = 0; i < LINES; i++) begin line_v[i] = 1'b0; line_at[i] = 32'h0; end

    // Reset state, with a load request already presented.
    repeat (2) @(negedge clk);
    #1;
    chk("rst.stall", 32'(bus.stall), 32'(0));
    chk("rst.mem_req", 32'(bus.mem_req), 32'(0));
    chk("rst.mem_we", 32'(bus.mem_we), 32'(0));
    chk("rst.mem_be", 32'(bus.mem_be), 32'(0));
    chk("rst.mem_addr", bus.mem_addr, 32'h0);
    chk("rst.mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst.cpu_rdata", bus.cpu_rdata, 32'h0);
    chk("rst.state", 32'(dbg_state), 32'(0));
    @(negedge clk);
    rstn = 1'b1;
    bus.cpu_read = 1'b0;
    @(negedge clk);

    // Cold read miss, slow memory.
    mem_model[32'h100] = 32'h11;
    mem_model[32'h104] = 32'h22;
    mem_model[32'h108] = 32'h33;
    mem_model[32'h10C] = 32'h44;
    mem_delay = 2;
    do_read(32'h0000_0104, "cold_read");
    mem_delay = 0;
    do_read(32'h0000_0108, "hit_read");

    // Byte store into a cached line, then read it back.
    do_write(32'h0000_0109, 32'h0000_00AB, 2'b10, "sb_hit");
    do_read(32'h0000_0109, "lbu_after_sb");
    do_read(32'h0000_0108, "lw_after_sb");
    chk("cached_word_const", bus.cpu_rdata === 32'h0 ? 32'h0 : mem_rd(32'h108), 32'h0000_AB33);

    // Half store that misses leaves the line unallocated.
    do_write(32'h0000_2002, 32'h0000_BEEF, 2'b01, "sh_miss");
    do_read(32'h0000_2000, "read_after_sh_miss");
    chk("sh_miss_refilled", 32'(log_addr_q.size()), 32'(4));

    // Conflict eviction.
    do_read(32'h0000_0100, "conf_a");
    do_read(32'h0000_0100 + 16 * LINES, "conf_b");
    do_read(32'h0000_0100, "conf_a_again");
    chk("conf_a_refilled", 32'(log_addr_q.size()), 32'(4));

    // Stray mem_ready with no request outstanding.
    spurious = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("spurious.state", 32'(dbg_state), 32'(0));
    chk("spurious.stall", 32'(bus.stall), 32'(0));
    @(negedge clk);
    spurious = 1'b0;
    do_read(32'h0000_0104, "after_spurious");

    // Reset in the middle of a refill.
    mem_delay = 1;
    clear_log();
    bus.cpu_addr = 32'h0000_0304;
    bus.cpu_read = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(log_addr_q.size() == 2 && bus.mem_ready === 1'b0) && n < 200);
    chk("mid_refill.reached", 32'(n < 200), 32'(1));
    chk("mid_refill.mem_req", 32'(bus.mem_req), 32'(1));
    rstn = 1'b0;
    #1;
    chk("mid_refill_rst.mem_req", 32'(bus.mem_req), 32'(0));
    chk("mid_refill_rst.stall", 32'(bus.stall), 32'(0));
    chk("mid_refill_rst.state", 32'(dbg_state), 32'(0));
    chk("mid_refill_rst.mem_addr", bus.mem_addr, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    bus.cpu_read = 1'b0;
    for (int i = 0; i < LINES; i++) line_v[i] = 1'b0;
    @(negedge clk);
    do_read(32'h0000_0304, "reread_after_rst");
    do_read(32'h0000_0108, "old_line_after_rst");

    // Random loads and stores over a few conflicting tags.
    mem_delay = -1;
    for (int k = 0; k < 150; k++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 2)) << (4 + $clog2(LINES))) | 32'h0001_0000 |
          (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0)
        do_write(a, $urandom, 2'($urandom_range(0, 3)), "rnd_write");
      else
        do_read(a, "rnd_read");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
